// File: rtl/wb_master_engine.sv
// Single-transfer Wishbone B3 classic master: one command in, one bus cycle (with retries), one response out.
// Optional watchdog built when WB_MASTER_ENGINE_TIMEOUT_EN is defined.
module wb_master_engine #(
    parameter int dw        = 32,
    parameter int aw        = 32,
    parameter int MAX_RETRY = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic          wb_clk,
    input  logic          wb_rst,

    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [aw-1:0] cmd_adr_i,
    input  logic [dw-1:0] cmd_dat_i,
    input  logic [3:0]    cmd_sel_i,

    output logic          rsp_valid_o,
    output logic [dw-1:0] rsp_dat_o,
    output logic [1:0]    rsp_status_o,

    output logic [aw-1:0] wb_adr_o,
    output logic [dw-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic [2:0]    wb_cti_o,
    output logic [1:0]    wb_bte_o,
    input  logic [dw-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i
);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERR     = 2'b01;
    localparam logic [1:0] ST_RETRY   = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    if (MAX_RETRY < 0 || MAX_RETRY > 15) begin : g_bad_max_retry
        $error("wb_master_engine: MAX_RETRY out of range");
    end
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("wb_master_engine: TIMEOUT out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        BACKOFF,
        RESP
    } state_t;

    state_t          state, state_next;
    logic [3:0]      retry_cnt, retry_next;
    logic [1:0]      status_next;
    logic            set_status;
    logic            load_cmd;
    logic            capture_rd;

    logic            req_we;
    logic [aw-1:0]   req_adr;
    logic [dw-1:0]   req_dat;
    logic [3:0]      req_sel;

`ifdef WB_MASTER_ENGINE_TIMEOUT_EN
    logic [7:0]      wdog_cnt;
    logic            wdog_clr;
    logic            wdog_inc;
`endif

    // Outputs decode straight from the state register so a reset drops cyc/stb without waiting for a clock.
    assign cmd_ready_o = (state == IDLE);
    assign rsp_valid_o = (state == RESP);
    assign wb_cyc_o    = (state == BUS);
    assign wb_stb_o    = (state == BUS);
    assign wb_adr_o    = req_adr;
    assign wb_dat_o    = req_dat;
    assign wb_sel_o    = req_sel;
    assign wb_we_o     = req_we;
    assign wb_cti_o    = 3'b000;
    assign wb_bte_o    = 2'b00;

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state     <= IDLE;
            retry_cnt <= 4'd0;
        end else begin
            state     <= state_next;
            retry_cnt <= retry_next;
        end
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            req_we  <= 1'b0;
            req_adr <= '0;
            req_dat <= '0;
            req_sel <= 4'd0;
        end else if (load_cmd) begin
            req_we  <= cmd_we_i;
            req_adr <= cmd_adr_i;
            req_dat <= cmd_dat_i;
            req_sel <= cmd_sel_i;
        end
    end

    // Status and read data are only touched on the edge that ends a transfer, so both hold between responses.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            rsp_status_o <= ST_OK;
            rsp_dat_o    <= '0;
        end else begin
            if (set_status) begin
                rsp_status_o <= status_next;
            end
            if (capture_rd) begin
                rsp_dat_o <= wb_dat_i;
            end
        end
    end

`ifdef WB_MASTER_ENGINE_TIMEOUT_EN
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            wdog_cnt <= 8'd0;
        end else if (wdog_clr) begin
            wdog_cnt <= 8'd0;
        end else if (wdog_inc && wdog_cnt != 8'hFF) begin
            wdog_cnt <= wdog_cnt + 8'd1;
        end
    end
`endif

    always_comb begin
        state_next  = state;
        retry_next  = retry_cnt;
        status_next = rsp_status_o;
        set_status  = 1'b0;
        load_cmd    = 1'b0;
        capture_rd  = 1'b0;
`ifdef WB_MASTER_ENGINE_TIMEOUT_EN
        wdog_clr    = 1'b0;
        wdog_inc    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid_i) begin
                    load_cmd   = 1'b1;
                    retry_next = 4'd0;
`ifdef WB_MASTER_ENGINE_TIMEOUT_EN
                    wdog_clr   = 1'b1;
`endif
                    state_next = BUS;
                end
            end
            BUS: begin
                // err outranks ack so a confused slave never gets its read data accepted.
                if (wb_err_i) begin
                    status_next = ST_ERR;
                    set_status  = 1'b1;
                    state_next  = RESP;
                end else if (wb_ack_i) begin
                    status_next = ST_OK;
                    set_status  = 1'b1;
                    capture_rd  = ~req_we;
                    state_next  = RESP;
                end else if (wb_rty_i) begin
                    if (retry_cnt < 4'(MAX_RETRY)) begin
                        retry_next = retry_cnt + 4'd1;
                        state_next = BACKOFF;
                    end else begin
                        status_next = ST_RETRY;
                        set_status  = 1'b1;
                        state_next  = RESP;
                    end
                end
`ifdef WB_MASTER_ENGINE_TIMEOUT_EN
                else if (wdog_cnt >= 8'(TIMEOUT - 1)) begin
                    status_next = ST_TIMEOUT;
                    set_status  = 1'b1;
                    state_next  = RESP;
                end else begin
                    wdog_inc = 1'b1;
                end
`endif
            end
            BACKOFF: begin
`ifdef WB_MASTER_ENGINE_TIMEOUT_EN
                wdog_clr   = 1'b1;
`endif
                state_next = BUS;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/wb_master_engine.md
# wb_master_engine

Single-transfer Wishbone B3 classic-cycle master that sits directly upstream of the team's Wishbone slave register blocks. It converts one-shot commands from the DSP control logic (address, data, write strobe) into bus cycles. It handles ack, error, retry and an optional watchdog, then returns one response per command.

## Interface
- `dw`, 32, data width
- `aw`, 32, address width
- `MAX_RETRY`, 4, number of re-issues allowed after `wb_rty_i` before giving up (range 0–15)
- `TIMEOUT`, 16, watchdog limit in cycles of a cycle without termination (range 2–255)
- `wb_clk` in 1: the only clock; everything is on the rising edge
- `wb_rst` in 1: reset, asynchronous and active-high
- `cmd_valid_i` in 1: command request
- `cmd_ready_o` out 1: engine idle and able to accept a command
- `cmd_we_i` in 1: 1 = write, 0 = read
- `cmd_adr_i` in aw: target address
- `cmd_dat_i` in dw: write data
- `cmd_sel_i` in 4: byte selects
- `rsp_valid_o` out 1: one-cycle response pulse
- `rsp_dat_o` out dw: read data; holds the last value until the next read completes
- `rsp_status_o` out 2: 00 ok, 01 bus error, 10 retries exhausted, 11 timeout
- `wb_adr_o` out aw, `wb_dat_o` out dw, `wb_sel_o` out 4, `wb_we_o` out 1: Wishbone request fields
- `wb_cyc_o` out 1, `wb_stb_o` out 1: Wishbone cycle/strobe; always equal
- `wb_cti_o` out 3: constant 3'b000 (classic)
- `wb_bte_o` out 2: constant 2'b00
- `wb_dat_i` in dw, `wb_ack_i` in 1, `wb_err_i` in 1, `wb_rty_i` in 1: slave response

## Operation
- FSM states: IDLE, BUS, BACKOFF, RESP. Reset state is IDLE.
- **IDLE:** `cmd_ready_o`=1.
  - On `cmd_valid_i` at an edge, latch we/adr/dat/sel into the request registers.
  - Clear the retry and watchdog counters, then go to BUS.
- **BUS:** `wb_cyc_o`=`wb_stb_o`=1. Request fields are stable from the latched command. The first edge where a termination input is high ends the cycle. Priority is err > ack > rty:
  - `err`: status 01, go to RESP.
  - `ack`: status 00, go to RESP. If it is a read, capture `wb_dat_i` into `rsp_dat_o` on that edge.
  - `rty` with retry count < MAX_RETRY: increment the count, go to BACKOFF.
  - `rty` with retry count == MAX_RETRY: status 10, go to RESP.
- **BACKOFF:** cyc/stb low for exactly one cycle, then back to BUS with the same request fields. The watchdog counter is cleared on re-entry to BUS.
- **RESP:** `rsp_valid_o`=1 for exactly one cycle, cyc/stb low, then go to IDLE.
- `cmd_ready_o`=0 in BUS, BACKOFF and RESP. A `cmd_valid_i` in those states is ignored; it is not queued.
- `rsp_status_o` holds its value until the next RESP.
- Write commands never modify `rsp_dat_o`.
- Retry counter is 4 bits; watchdog counter is 8 bits and saturates.

## Timing
- Reset values: `cmd_ready_o`=1; `rsp_valid_o`=0, `rsp_dat_o`=0, `rsp_status_o`=00; `wb_cyc_o`=`wb_stb_o`=`wb_we_o`=0; `wb_adr_o`, `wb_dat_o`, `wb_sel_o`=0.
- Command accepted at edge E0:
  - cyc/stb high in the cycle after E0.
  - Termination sampled at edge Ek.
  - `rsp_valid_o` high in the cycle after Ek.
- Against a slave with registered ack (one wait state), a command accepted at E0 gives stb at cycle 1, ack at cycle 2 and `rsp_valid_o` at cycle 3.
- Each retry adds 1 BACKOFF cycle plus the new bus cycle.
- Back-to-back commands: the next command is accepted at the earliest in the cycle after RESP, so there is a minimum of 3 cycles per transfer.
- A termination input that arrives outside BUS is ignored.
- Asserting `wb_rst` mid-cycle drops cyc/stb immediately (asynchronous), discards the command, and produces no response.

## Configuration
- Macro `WB_MASTER_ENGINE_TIMEOUT_EN`.
- **Defined:** in BUS the watchdog counts cycles with no termination.
  - When the count reaches TIMEOUT, drop cyc/stb, set status 11 and go to RESP.
  - A termination on the same edge as the limit takes precedence over the timeout.
- **Undefined:** no watchdog logic is built and BUS waits indefinitely. Status 11 is never produced.

## Test plan
- Write 0xDEADBEEF to 0x4, sel 0xF, slave acks after 1 wait: one bus cycle with we=1, adr=0x4 → `rsp_valid_o` at cycle 3, status 00, `rsp_dat_o` unchanged.
- Read 0x8, slave returns 0x12345678 with ack → `rsp_dat_o`=0x12345678, status 00, a single 1-cycle `rsp_valid_o` pulse.
- Slave asserts rty 3 times then ack, MAX_RETRY=4 → 4 bus cycles separated by 1-cycle gaps, status 00. Slave rty 5 times → 5 bus cycles, status 10.
- err and ack asserted together → status 01, no read data captured.
- With `WB_MASTER_ENGINE_TIMEOUT_EN` and TIMEOUT=16, slave silent → cyc drops after 16 cycles, status 11. Without the macro, cyc is still high after 1000 cycles.
- `wb_rst` pulsed while cyc=1 → cyc/stb low immediately, no `rsp_valid_o`, `cmd_ready_o`=1, next command completes normally.
